// File: rtl/add_sub_serial_pkg.sv
// Shared types and helpers for the slice-serial add/sub block.
package add_sub_pkg;

  // Controller states: waiting for operands, stepping slices, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcode values carried on the control input.
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Default geometry: a 16-bit datapath stepped one byte per clock.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 8;

  // Signed two's-complement overflow, decided from the sign bits only.
  // Add overflows when like-signed operands give a result of the other sign;
  // subtract overflows when unlike-signed operands give a result whose sign
  // differs from the minuend.
  function automatic logic signed_ovf(input logic op, input logic sign_a,
                                      input logic sign_b, input logic sign_r);
    logic v;
    if (op == OP_ADD) begin
      v = (sign_a == sign_b) && (sign_r != sign_a);
    end else begin
      v = (sign_a != sign_b) && (sign_r != sign_a);
    end
    return v;
  endfunction

endpackage

// File: rtl/add_sub_serial_if.sv
// Operand and result channels of add_sub_serial.
//
// Both channels use the same valid/ready rule: a transfer happens on a rising
// clock edge where valid and ready are both high. The sender keeps valid and
// its payload steady until that edge; the receiver may raise or drop ready at
// any time. Nothing is transferred on an edge where either one is low.
interface add_sub_serial_if
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  // Operand channel (producer -> block)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             control;

  // Result channel (block -> consumer)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             ovf;

  // Producer/consumer side of the block.
  modport master (
    output in_valid, a, b, control, out_ready,
    input  in_ready, out_valid, result, carry_out, ovf
  );

  // The arithmetic block itself.
  modport slave (
    input  in_valid, a, b, control, out_ready,
    output in_ready, out_valid, result, carry_out, ovf
  );

endinterface

// File: rtl/add_sub_serial_slice.sv
// One SLICE-bit add/subtract step with carry/borrow in and out.
module add_sub_slice
  import add_sub_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             op,
  input  logic             c_in,
  output logic [SLICE-1:0] res_s,
  output logic             c_out
);

  // One extra bit on top catches the carry on add; on subtract it goes to 1
  // exactly when the difference would be negative, which is the borrow.
  logic [SLICE:0] acc;

  // Compute the slice sum or difference including the incoming carry/borrow.
  always_comb begin
    acc = '0;
    if (op == OP_ADD) begin
      acc = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, c_in};
    end else begin
      acc = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, c_in};
    end
    res_s = acc[SLICE-1:0];
    c_out = acc[SLICE];
  end

endmodule

// File: rtl/add_sub_serial.sv
// Slice-serial add/subtract: takes an operand pair, walks it LSB slice first
// through a single slice adder, then presents result and flags until taken.
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic              clk,
  input  logic              rst,
  add_sub_serial_if.slave   bus,
  output state_t            dbg_state
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  // Operands and result are kept slice-addressable so the index counter can
  // pick one slice per cycle without shifting the whole word.
  typedef logic [NUM_SLICES-1:0][SLICE-1:0] word_t;

  state_t           state_q, state_d;
  word_t            a_q, a_d;
  word_t            b_q, b_d;
  word_t            res_q, res_d;
  logic             op_q, op_d;
  logic             cy_q, cy_d;          // running carry/borrow between slices
  logic             carry_out_q, carry_out_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             in_ready;
  logic             accept;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] res_s;
  logic             c_out;

  // Ready only while idle, and never while reset is asserted so no operand
  // can be taken on an edge that is about to be discarded.
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = bus.in_valid && in_ready;

  assign a_s = a_q[idx_q];
  assign b_s = b_q[idx_q];

  add_sub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_s   (a_s),
    .b_s   (b_s),
    .op    (op_q),
    .c_in  (cy_q),
    .res_s (res_s),
    .c_out (c_out)
  );

  // Next-state and datapath updates for the accept / step / hold sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    op_d        = op_q;
    cy_d        = cy_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Operands are captured here only; later changes on the bus are
          // invisible to the running operation.
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.control;
          cy_d    = 1'b0;
          idx_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        res_d[idx_q] = res_s;
        cy_d         = c_out;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // The top slice carries the sign bits, so the flags settle here.
          carry_out_d = c_out;
          ovf_d       = signed_ovf(op_q, a_q[NUM_SLICES-1][SLICE-1],
                                   b_q[NUM_SLICES-1][SLICE-1], res_s[SLICE-1]);
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      op_q        <= OP_SUB;
      cy_q        <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      op_q        <= op_d;
      cy_q        <= cy_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.carry_out = carry_out_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_add_sub_serial;
  import add_sub_pkg::*;

  localparam int W  = 16;
  localparam int SL = 8;
  localparam int NS = W / SL;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  add_sub_serial_if #(.WIDTH(W)) bus_if ();

  add_sub_serial #(
    .WIDTH (W),
    .SLICE (SL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W+1:0] exp_q[$];   // {carry, ovf, result}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full words.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic add);
    int unsigned ux, uy, ur;
    int          sx, sy, sr;
    logic [W-1:0] r;
    logic         c, v;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (add) begin
      ur = ux + uy;
      c  = (ur > 32'd65535);
      sr = sx + sy;
    end else begin
      ur = ux - uy;
      c  = (ux < uy);
      sr = sx - sy;
    end
    r = ur[W-1:0];
    v = (sr > 32767) || (sr < -32768);
    return {c, v, r};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    v = W'($urandom_range(0, 65535));
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 4))
        0: v = 16'h0000;
        1: v = 16'hFFFF;
        2: v = 16'h7FFF;
        3: v = 16'h8000;
        default: v = 16'h0001;
      endcase
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the block idle. Sends one op, checks latency and
  // the result, optionally holds out_ready low for 'hold' cycles (with a new
  // op pending when bp=1), then takes the result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                        input int hold, input bit scramble, input bit bp,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic nop);
    logic [W+1:0] e;
    int cyc;
    int lat;
    exp_q.push_back(model(ta, tb_v, top));
    bus_if.in_valid = 1'b1;
    bus_if.a        = ta;
    bus_if.b        = tb_v;
    bus_if.control  = top;
    cyc = 0;
    while (bus_if.in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_wait", cyc, 0);
    if (bus_if.in_ready !== 1'b1) begin
      bus_if.in_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(negedge clk);  // accept edge has passed
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 50) begin
      if (scramble) begin
        bus_if.a       = W'($urandom_range(0, 65535));
        bus_if.b       = W'($urandom_range(0, 65535));
        bus_if.control = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NS);
    e = exp_q.pop_front();
    if (bus_if.out_valid !== 1'b1) return;
    chk("result", bus_if.result, e[W-1:0]);
    chk("carry_out", bus_if.carry_out, e[W+1]);
    chk("ovf", bus_if.ovf, e[W]);
    if (bp) begin
      bus_if.in_valid = 1'b1;
      bus_if.a        = na;
      bus_if.b        = nb;
      bus_if.control  = nop;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus_if.out_valid, 1);
      chk("hold_in_ready", bus_if.in_ready, 0);
      chk("hold_result", bus_if.result, e[W-1:0]);
      chk("hold_flags", {bus_if.carry_out, bus_if.ovf}, e[W+1:W]);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    chk("valid_drop", bus_if.out_valid, 0);
    chk("ready_back", bus_if.in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.control   = 1'b0;
    bus_if.out_ready = 1'b0;
    rst = 1'b1;
    bus_if.in_valid = 1'b1;  // must be ignored during reset
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus_if.in_ready, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    bus_if.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus_if.in_ready, 1);
    chk("post_rst_result", bus_if.result, 0);
    chk("post_rst_flags", {bus_if.carry_out, bus_if.ovf}, 0);
    chk("post_rst_state", dbg_state, IDLE);
    @(negedge clk);

    // Directed arithmetic corners
    run_op(16'h12FF, 16'h0001, OP_ADD, 0, 0, 0, '0, '0, 0);
    run_op(16'h1300, 16'h0001, OP_SUB, 0, 0, 0, '0, '0, 0);
    run_op(16'h0000, 16'h0001, OP_SUB, 0, 0, 0, '0, '0, 0);
    run_op(16'hFFFF, 16'h0001, OP_ADD, 0, 0, 0, '0, '0, 0);
    run_op(16'h7FFF, 16'h0001, OP_ADD, 0, 0, 0, '0, '0, 0);
    run_op(16'h8000, 16'h0001, OP_SUB, 0, 0, 0, '0, '0, 0);

    // Backpressure with a second op pending, then that op itself
    run_op(16'h1234, 16'h4321, OP_ADD, 5, 0, 1, 16'hA5A5, 16'h0F0F, OP_SUB);
    run_op(16'hA5A5, 16'h0F0F, OP_SUB, 0, 0, 0, '0, '0, 0);

    // Operands wiggling during CALC
    run_op(16'h4000, 16'h4000, OP_ADD, 0, 1, 0, '0, '0, 0);
    run_op(16'h0005, 16'h8003, OP_SUB, 0, 1, 0, '0, '0, 0);

    // Reset after the first slice of an add
    bus_if.in_valid = 1'b1;
    bus_if.a        = 16'h00FF;
    bus_if.b        = 16'h0001;
    bus_if.control  = OP_ADD;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_calc_valid", bus_if.out_valid, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", bus_if.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", bus_if.out_valid, 0);
    chk("abort_result", bus_if.result, 0);
    chk("abort_flags", {bus_if.carry_out, bus_if.ovf}, 0);
    chk("abort_in_ready", bus_if.in_ready, 1);
    chk("abort_state", dbg_state, IDLE);
    @(negedge clk);
    // Resumes well-formed after the abort and still at full speed.
    bus_if.out_ready = 1'b0;
    run_op(16'h0003, 16'h0005, OP_SUB, 0, 0, 0, '0, '0, 0);

    // Randomized operations
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] ra, rb, rna, rnb;
      logic         rop, rnop;
      int           rh;
      bit           rbp;
      ra   = rnd_operand();
      rb   = rnd_operand();
      rop  = 1'($urandom_range(0, 1));
      rh   = $urandom_range(0, 3);
      rbp  = (rh > 0) && ($urandom_range(0, 1) == 1);
      rna  = rnd_operand();
      rnb  = rnd_operand();
      rnop = 1'($urandom_range(0, 1));
      run_op(ra, rb, rop, rh, 1'($urandom_range(0, 1)), rbp, rna, rnb, rnop);
      if (rbp) run_op(rna, rnb, rnop, 0, 0, 0, '0, '0, 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Sequential, slice-serial companion to the team's combinational 16-bit add/sub datapath: it accepts an operand pair and opcode over a valid/ready handshake and computes one SLICE-bit slice per clock, LSB slice first. Carry or borrow is held in a register between slices. The block returns the result, a carry/borrow flag and a signed-overflow flag over a second valid/ready handshake. It sits between an operand producer and a result consumer where area matters more than throughput.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits processed per cycle; NUM_SLICES = WIDTH/SLICE (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair and opcode valid
- in_ready  out  1  block can accept; high only in IDLE and low while rst=1
- a  in  WIDTH  operand A, unsigned/two's complement
- b  in  WIDTH  operand B
- control  in  1  1 = add (a+b), 0 = subtract (a−b)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  (a ± b) mod 2^WIDTH
- carry_out  out  1  add: carry out of MSB; sub: borrow (1 iff a < b unsigned)
- ovf  out  1  signed two's-complement overflow of the operation

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register a, b and control; clear carry register and slice index; go to CALC.
- CALC: each cycle, combine slice[idx] of the registered a and b with the carry register.
  - Add: sum = a_s + b_s + c.
  - Sub: diff = a_s − b_s − c; c is the borrow.
  - Write the SLICE-bit result into result[idx]; store the carry/borrow; idx++.
  - On the last slice, also compute ovf and go to DONE.
- ovf rule. Add: sign(a)==sign(b) and sign(result)≠sign(a). Sub: sign(a)≠sign(b) and sign(result)≠sign(a).
- DONE: out_valid=1; result, carry_out and ovf are stable. On out_ready, go to IDLE.
- Inputs a, b and control are ignored outside the accept cycle. Changing them during CALC or DONE has no effect.
- in_valid is ignored in CALC and DONE. Ops are never overlapped or dropped silently; a producer holds in_valid until accepted.
- Reset, at any state including mid-CALC:
  - next state IDLE;
  - result=0, carry_out=0, ovf=0, out_valid=0;
  - carry register and slice index cleared;
  - an in-flight op is discarded.

## Timing
- Accept edge E0. Slice k is computed on edge E0+1+k. out_valid rises after edge E0+NUM_SLICES, so it is high 2 cycles after accept for the defaults.
- The result is presented with zero extra latency beyond that edge; all outputs are registered.
- Throughput: at best one op per NUM_SLICES+2 cycles (accept, NUM_SLICES CALC, DONE with out_ready=1, return to IDLE).
- out_ready=1 on the first DONE cycle: the handshake completes on that edge and in_ready=1 on the next cycle.
- Backpressure: DONE holds indefinitely and all outputs stay frozen.
- After reset deasserts, in_ready=1 on the first cycle with rst=0.
- NUM_SLICES=1: CALC lasts exactly one cycle.

## Structure
- Package add_sub_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - opcode constants OP_ADD=1'b1, OP_SUB=1'b0;
  - a function for the signed-overflow rule.
- Sub-module add_sub_slice: combinational, parameter SLICE. Ports a_s, b_s, op, c_in, res_s, c_out, with the same carry/borrow semantics as above. One instance is reused every CALC cycle.
- The top level holds the FSM, operand/result registers, slice index counter and carry register.

## Test plan
- Add with cross-slice carry: a=0x12FF, b=0x0001, control=1. Expect result=0x1300, carry_out=0, ovf=0, out_valid exactly 2 cycles after the accept edge.
- Subtract with cross-slice borrow: a=0x1300, b=0x0001, control=0. Expect result=0x12FF, carry_out=0, ovf=0.
- Wrap-around and flags:
  - 0x0000−0x0001 gives 0xFFFF, carry_out=1, ovf=0.
  - 0xFFFF+0x0001 gives 0x0000, carry_out=1, ovf=0.
  - 0x7FFF+0x0001 gives 0x8000, ovf=1.
  - 0x8000−0x0001 gives 0x7FFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands. Expect result and flags constant, in_ready=0, no second op accepted. Release out_ready; the second op is accepted the cycle after and computed correctly.
- Operand stability: change a and b every cycle during CALC. Expect the result to equal the operation on the values present at the accept edge.
- Reset mid-operation: assert rst for one cycle after the first CALC slice of 0x00FF+0x0001. Expect out_valid=0, result=0, carry_out=0, ovf=0. in_ready=1 on the next cycle. A following 0x0003−0x0005 yields 0xFFFE with carry_out=1.
